// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and the loader state type.
// Used by the loader and by the instruction-memory blocks.
package imem_pkg;

   localparam int IMEM_BYTES  = 2048;
   localparam int IMEM_ADDR_W = 11;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERR
   } loader_state_e;

   // A load length is usable only if non-empty, whole words, and fits the memory.
   function automatic logic len_ok(input logic [15:0] len);
      return (len != 16'd0) && (len[1:0] == 2'b00) && (len <= 16'(IMEM_BYTES));
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: 16-bit LE length, payload packed into LE words.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader
   import imem_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic [7:0]             i_byte,
   input  logic                   i_valid,
   output logic                   o_ready,
   output logic                   o_we,
   output logic [IMEM_ADDR_W-1:0] o_waddr,
   output logic [31:0]            o_wdata,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err
);

   loader_state_e          state_q, state_d;
   logic [7:0]             len_lo_q, len_lo_d;
   logic [IMEM_ADDR_W:0]   len_q, len_d;
   logic [IMEM_ADDR_W-1:0] cnt_q, cnt_d;
   logic [31:0]            wbuf_q, wbuf_d;
   logic                   we_q, we_d;
   logic [IMEM_ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]            wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]             csum_q, csum_d;
`endif

   logic        xfer;
   logic        last_byte;
   logic [15:0] len_full;
   logic [31:0] wbuf_ins;

   assign o_ready = (state_q == LEN0) || (state_q == LEN1) ||
                    (state_q == DATA) || (state_q == CSUM);
   assign o_busy  = o_ready;
   assign o_done  = (state_q == DONE);
   assign o_err   = (state_q == ERR);
   assign o_we    = we_q;
   assign o_waddr = waddr_q;
   assign o_wdata = wdata_q;

   assign xfer      = i_valid && o_ready;
   assign len_full  = {i_byte, len_lo_q};
   assign last_byte = ({1'b0, cnt_q} == (len_q - {{IMEM_ADDR_W{1'b0}}, 1'b1}));

   // Word buffer with the incoming byte dropped into its lane.
   always_comb begin
      wbuf_ins = wbuf_q;
      wbuf_ins[{cnt_q[1:0], 3'b000} +: 8] = i_byte;
   end

   always_comb begin
      state_d  = state_q;
      len_lo_d = len_lo_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      wbuf_d   = wbuf_q;
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      case (state_q)
         IDLE, DONE, ERR: begin
            if (i_start) begin
               state_d = LEN0;
               cnt_d   = '0;
               wbuf_d  = '0;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         LEN0: begin
            if (xfer) begin
               len_lo_d = i_byte;
               state_d  = LEN1;
            end
         end
         LEN1: begin
            if (xfer) begin
               if (len_ok(len_full)) begin
                  len_d   = len_full[IMEM_ADDR_W:0];
                  state_d = DATA;
               end else begin
                  state_d = ERR;
               end
            end
         end
         DATA: begin
            if (xfer) begin
               wbuf_d = wbuf_ins;
               cnt_d  = cnt_q + {{(IMEM_ADDR_W-1){1'b0}}, 1'b1};
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ i_byte;
`endif
               // Fourth lane filled: issue the word write on the following cycle.
               if (cnt_q[1:0] == 2'b11) begin
                  we_d    = 1'b1;
                  waddr_d = {cnt_q[IMEM_ADDR_W-1:2], 2'b00};
                  wdata_d = wbuf_ins;
               end
               if (last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = CSUM;
`else
                  state_d = DONE;
`endif
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CSUM: begin
            if (xfer) begin
               state_d = (i_byte == csum_q) ? DONE : ERR;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         len_lo_q <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         wbuf_q   <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         len_lo_q <= len_lo_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         wbuf_q   <= wbuf_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader; expected words come from the byte list.
// Define LOADER_CHECKSUM_EN for both RTL and bench to exercise the checksum build.
module tb_imem_loader;

   logic        i_clk   = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [7:0]  i_byte  = 8'h00;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic        o_we;
   logic [10:0] o_waddr;
   logic [31:0] o_wdata;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   imem_loader dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (i_start),
      .i_byte  (i_byte),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_we    (o_we),
      .o_waddr (o_waddr),
      .o_wdata (o_wdata),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_err   (o_err)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Write log and hold-stability monitor, sampled mid-cycle.
   logic [10:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];
   int          hold_viol = 0;
   logic [10:0] prev_a    = '0;
   logic [31:0] prev_d    = '0;
   logic        prev_rst  = 1'b0;

   always @(negedge i_clk) begin
      if (o_we === 1'b1) begin
         wa_q.push_back(o_waddr);
         wd_q.push_back(o_wdata);
         wc_q.push_back(cyc);
      end
      if (i_rst_n && prev_rst && (o_we !== 1'b1) &&
          ((o_waddr !== prev_a) || (o_wdata !== prev_d)))
         hold_viol++;
      prev_a   = o_waddr;
      prev_d   = o_wdata;
      prev_rst = i_rst_n;
   end

   int         n_checks = 0;
   int         n_fail   = 0;
   int         acc_cyc  = 0;
   logic [7:0] pay[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
   endtask

   // Present one byte (after gap idle cycles) for exactly one clock edge.
   task automatic send(input logic [7:0] b, input int gap);
      i_valid = 1'b0;
      repeat (gap) begin
         i_byte = 8'($urandom);
         @(negedge i_clk);
      end
      i_valid = 1'b1;
      i_byte  = b;
      @(posedge i_clk);
      #1 acc_cyc = cyc;
      @(negedge i_clk);
      i_valid = 1'b0;
      i_byte  = 8'($urandom);
   endtask

   task automatic start_session();
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic send_len(input int len);
      logic [15:0] l16;
      l16 = 16'(len);
      send(l16[7:0], 0);
      send(l16[15:8], 0);
   endtask

   function automatic logic [7:0] pay_xor();
      logic [7:0] x;
      x = 8'h00;
      foreach (pay[i]) x = x ^ pay[i];
      return x;
   endfunction

   // Reference: word j holds payload bytes 4j..4j+3, lowest byte in bits 7:0, at address 4j.
   task automatic check_words(input string tag, input int nwords);
      chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(nwords));
      for (int j = 0; j < nwords && j < wa_q.size(); j++) begin
         chk({tag, "_addr"}, 32'(wa_q[j]), 32'(4 * j));
         chk({tag, "_data"}, wd_q[j],
             {pay[4*j+3], pay[4*j+2], pay[4*j+1], pay[4*j]});
      end
   endtask

   task automatic run_session(input string tag, input int len, input int maxgap);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      clear_log();
      start_session();
      send_len(len);
      for (int i = 0; i < len; i++) send(pay[i], $urandom_range(0, maxgap));
`ifdef LOADER_CHECKSUM_EN
      send(pay_xor(), $urandom_range(0, maxgap));
`endif
      tick(2);
      check_words(tag, len / 4);
      chk({tag, "_done"}, o_done, 1'b1);
      chk({tag, "_busy"}, o_busy, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #1;
      chk("rst_we",    o_we,    1'b0);
      chk("rst_ready", o_ready, 1'b0);
      chk("rst_busy",  o_busy,  1'b0);
      chk("rst_done",  o_done,  1'b0);
      chk("rst_err",   o_err,   1'b0);
      chk("rst_waddr", 32'(o_waddr), 32'd0);
      chk("rst_wdata", o_wdata, 32'd0);
      tick(3);
      i_rst_n = 1'b1;
      tick(2);
      chk("idle_ready", o_ready, 1'b0);

      // Known 8-byte program
      pay = '{8'hb7, 8'h3f, 8'h00, 8'h10, 8'h37, 8'h2f, 8'h00, 8'h10};
      clear_log();
      start_session();
      chk("A_ready_len0", o_ready, 1'b1);
      send_len(8);
      foreach (pay[i]) send(pay[i], 0);
      chk("A_we_last", o_we, 1'b1);
`ifdef LOADER_CHECKSUM_EN
      chk("A_busy_csum", o_busy, 1'b1);
      send(pay_xor(), 0);
`else
      chk("A_done_direct", o_done, 1'b1);
`endif
      tick(2);
      chk("A_nwrites", 32'(wa_q.size()), 32'd2);
      if (wa_q.size() == 2) begin
         chk("A_addr0", 32'(wa_q[0]), 32'd0);
         chk("A_data0", wd_q[0], 32'h10003fb7);
         chk("A_addr1", 32'(wa_q[1]), 32'd4);
         chk("A_data1", wd_q[1], 32'h10002f37);
      end
      chk("A_done",  o_done,  1'b1);
      chk("A_ready", o_ready, 1'b0);

      // Length not a multiple of 4
      clear_log();
      start_session();
      chk("B_done_cleared", o_done, 1'b0);
      send_len(6);
      send(8'hAA, 0);
      tick(2);
      chk("B_err",     o_err,   1'b1);
      chk("B_ready",   o_ready, 1'b0);
      chk("B_busy",    o_busy,  1'b0);
      chk("B_nwrites", 32'(wa_q.size()), 32'd0);

      // One word with idle gaps, write latency
      pay.delete();
      for (int i = 0; i < 4; i++) pay.push_back(8'($urandom));
      clear_log();
      start_session();
      chk("C_err_cleared", o_err, 1'b0);
      send_len(4);
      for (int i = 0; i < 4; i++) send(pay[i], 3);
      tick(3);
      check_words("C", 1);
      if (wc_q.size() == 1) chk("C_latency", 32'(wc_q[0]), 32'(acc_cyc));
`ifdef LOADER_CHECKSUM_EN
      send(pay_xor(), 0);
      tick(1);
`endif
      chk("C_done", o_done, 1'b1);

      // Reset in the middle of a session
      pay.delete();
      for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
      clear_log();
      start_session();
      send_len(8);
      for (int i = 0; i < 5; i++) send(pay[i], 0);
      #2 i_rst_n = 1'b0;
      #1;
      chk("D_we",    o_we,    1'b0);
      chk("D_ready", o_ready, 1'b0);
      chk("D_busy",  o_busy,  1'b0);
      chk("D_done",  o_done,  1'b0);
      chk("D_err",   o_err,   1'b0);
      chk("D_waddr", 32'(o_waddr), 32'd0);
      chk("D_wdata", o_wdata, 32'd0);
      tick(3);
      check_words("D", 1);
      i_rst_n = 1'b1;
      tick(2);
      chk("D_idle_busy", o_busy, 1'b0);
      run_session("D_reload", 8, 1);

      // Start while busy is ignored
      pay.delete();
      for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
      clear_log();
      start_session();
      send_len(8);
      for (int i = 0; i < 8; i++) begin
         i_start = (i == 3);
         send(pay[i], 0);
      end
      i_start = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      send(pay_xor(), 0);
`endif
      tick(2);
      check_words("S", 2);
      chk("S_done", o_done, 1'b1);

`ifdef LOADER_CHECKSUM_EN
      pay = '{8'h01, 8'h02, 8'h03, 8'h04};
      clear_log();
      start_session();
      send_len(4);
      foreach (pay[i]) send(pay[i], 0);
      send(8'h04, 0);
      tick(1);
      chk("K_good_done", o_done, 1'b1);
      check_words("K_good", 1);
      clear_log();
      start_session();
      send_len(4);
      foreach (pay[i]) send(pay[i], 0);
      send(8'h05, 0);
      tick(1);
      chk("K_bad_err", o_err, 1'b1);
      chk("K_bad_done", o_done, 1'b0);
      check_words("K_bad", 1);
      if (wd_q.size() == 1) chk("K_bad_word", wd_q[0], 32'h04030201);
`endif

      // Randomized sessions
      repeat (3) run_session("R", 4 * $urandom_range(1, 16), 2);

      // Full memory, then oversize and empty lengths
      run_session("E", 2048, 0);
      if (wa_q.size() > 0) chk("E_last_addr", 32'(wa_q[wa_q.size()-1]), 32'd2044);
      foreach (wa_q[i]) if (wa_q[i] > 11'd2044) hold_viol++;
      clear_log();
      start_session();
      send_len(2052);
      tick(2);
      chk("F_err",     o_err, 1'b1);
      chk("F_nwrites", 32'(wa_q.size()), 32'd0);
      start_session();
      send_len(0);
      tick(2);
      chk("Z_err", o_err, 1'b1);

      chk("hold_stable", 32'(hold_viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
